mmio_port_ctrl: RTL and testbench
=================================

MMIO_PORT_CTRL -- requirements
Module: mmio_port_ctrl

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1001_0000: base of a 16-byte register window.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port Address, input, 32: processor byte address.
REQ-005 The block SHALL have port WriteData, input, 32: processor store data.
REQ-006 The block SHALL have port MemWrite, input, 1: store strobe, qualified by address hit.
REQ-007 The block SHALL have port MemRead, input, 1: load strobe, qualified by address hit.
REQ-008 The block SHALL have port ReadData, output, 32: load data (combinational).
REQ-009 The block SHALL have port PortIn, input, 8: device byte; stable from PortInValid rise until PortInAck.
REQ-010 The block SHALL have port PortInValid, input, 1: asynchronous device strobe; rising edge offers a byte.
REQ-011 The block SHALL have port PortInAck, output, 1: one-cycle pulse when a byte is captured.
REQ-012 The block SHALL have port PortOut, output, 32: output data register.
REQ-013 The block SHALL have port PortOutValid, output, 1: PortOut holds an unaccepted word.
REQ-014 The block SHALL have port PortOutReady, input, 1: device accepts PortOut (synchronous to clk).

Function
REQ-015 Address decode SHALL be: hit = (Address[31:4] == BASE_ADDR[31:4]); offset = Address[3:2]; Address[1:0] ignored.
REQ-016 Registers SHALL be: offset 0 DATA_OUT (RW), offset 1 DATA_IN (RO), offset 2 STATUS (R, W1C), offset 3 unmapped.
REQ-017 ReadData SHALL be 0 unless MemRead & hit, as follows:
- DATA_OUT returns PortOut.
- DATA_IN returns {24'b0, rx_byte}.
- STATUS returns {28'b0, TX_DROP, RX_OVERRUN, TX_BUSY, RX_FULL}.
- Offset 3 returns 0.
REQ-018 PortInValid SHALL pass through a two-flop synchroniser (s1, s2) plus a history flop s3; capture condition = s2 & ~s3.
REQ-019 On capture with RX_FULL=0 (or a simultaneous pop), rx_byte<=PortIn, RX_FULL<=1, PortInAck=1 for exactly that next cycle.
REQ-020 Capture occurs on the third rising clk edge at which PortInValid is sampled high.
REQ-021 Capture with RX_FULL=1 and no pop SHALL:
- keep rx_byte;
- set sticky RX_OVERRUN;
- still pulse PortInAck.
REQ-022 MemRead & hit & offset 1 SHALL pop: RX_FULL<=0 at the edge.
REQ-023 When pop and capture coincide, the new byte SHALL be loaded, RX_FULL SHALL remain 1, and no overrun SHALL be flagged.
REQ-024 TX FSM states SHALL be TX_IDLE and TX_SEND; TX_BUSY = (state == TX_SEND); PortOutValid = TX_BUSY (registered).
REQ-025 In TX_IDLE, MemWrite & hit & offset 0 SHALL load PortOut<=WriteData and go to TX_SEND; PortOutValid is high the next cycle.
REQ-026 In TX_SEND, PortOutReady=1 at an edge SHALL return the FSM to TX_IDLE; PortOut holds its value.
REQ-027 In TX_SEND, a DATA_OUT write SHALL be dropped (PortOut unchanged) and set sticky TX_DROP, including on the cycle of acceptance.
REQ-028 A STATUS write SHALL clear RX_OVERRUN if WriteData[2]=1 and TX_DROP if WriteData[3]=1; other bits are ignored.
REQ-029 A set event SHALL win over a same-cycle W1C clear.
REQ-030 Writes to DATA_IN or offset 3, and all accesses with hit=0, SHALL have no effect.
REQ-031 MemRead and MemWrite asserted together SHALL both take effect independently.

Reset
REQ-032 While reset=0 the following SHALL be held, independent of clk:
- PortOut=0, PortOutValid=0, PortInAck=0;
- rx_byte=0, RX_FULL=0, RX_OVERRUN=0, TX_DROP=0;
- s1=s2=s3=0, FSM in TX_IDLE.
REQ-033 Reset mid-transfer SHALL abort it with no further PortOutValid or PortInAck.
REQ-034 After deassertion, a PortInValid still high SHALL produce one capture, since s3 restarts at 0.

Verification
REQ-035 Receive scenario:
- Stimulus: PortIn=8'hA5, raise PortInValid.
- Response: PortInAck pulses on the 3rd edge; STATUS reads 1; DATA_IN reads 32'h0000_00A5; STATUS then reads 0.
REQ-036 Overrun scenario:
- Stimulus: capture 8'h11, then capture 8'h22 without a read.
- Response: DATA_IN reads 8'h11; STATUS reads 32'h5; a STATUS write of 32'h4 then reads 32'h0.
REQ-037 Transmit scenario:
- Stimulus: write DATA_OUT=32'hDEAD_BEEF with PortOutReady=0 for 4 cycles, then 1.
- Response: PortOutValid high 5 cycles; PortOut=32'hDEAD_BEEF; STATUS bit1 clears after acceptance.
REQ-038 Drop scenario:
- Stimulus: write 32'h1234 while TX_SEND holds 32'h1.
- Response: PortOut stays 32'h1; STATUS reads 32'h8.
REQ-039 Simultaneous pop and capture:
- Stimulus: pop on the same edge as capture of 8'h7E.
- Response: RX_FULL=1, rx_byte=8'h7E, RX_OVERRUN=0.
REQ-040 Reset mid-transfer:
- Stimulus: assert reset (0) mid-TX_SEND between clock edges.
- Response: PortOutValid=0 and PortOut=0 immediately; an unmapped read at BASE_ADDR+12 returns 0.

Source files
------------

// File: rtl/mmio_port_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_port_ctrl
//
// Memory-mapped I/O port controller for a simple load/store processor.
// A 16-byte register window at BASE_ADDR exposes a transmit data register, a
// one-byte receive buffer and a status register with write-one-to-clear flags.
//
//   offset 0  DATA_OUT  RW  write launches a word on PortOut (dropped if busy)
//   offset 1  DATA_IN   RO  received byte; a read pops the buffer
//   offset 2  STATUS    R/W1C {TX_DROP, RX_OVERRUN, TX_BUSY, RX_FULL}
//   offset 3  unmapped, reads 0
//
// Ports
//   clk            single clock, all state updates on its rising edge
//   reset          asynchronous active-low reset
//   Address        processor byte address (bits [1:0] ignored)
//   WriteData      processor store data
//   MemWrite       store strobe, qualified by address hit
//   MemRead        load strobe, qualified by address hit
//   ReadData       combinational load data, 0 when not reading this window
//   PortIn         device byte, stable from PortInValid rise until PortInAck
//   PortInValid    asynchronous device strobe, rising edge offers a byte
//   PortInAck      one-cycle pulse when an offered byte has been taken
//   PortOut        output data register
//   PortOutValid   PortOut holds a word the device has not yet accepted
//   PortOutReady   device accepts PortOut (synchronous to clk)
// -----------------------------------------------------------------------------
module mmio_port_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  input  logic [7:0]  PortIn,
  input  logic        PortInValid,
  output logic        PortInAck,
  output logic [31:0] PortOut,
  output logic        PortOutValid,
  input  logic        PortOutReady
);

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  localparam logic [1:0] OFF_DATA_OUT = 2'd0;
  localparam logic [1:0] OFF_DATA_IN  = 2'd1;
  localparam logic [1:0] OFF_STATUS   = 2'd2;

  // Address decode
  logic       hit;
  logic [1:0] offset;
  logic       wr_data_out;
  logic       wr_status;
  logic       rd_data_in;
  logic       addr_unused;

  assign hit         = (Address[31:4] == BASE_ADDR[31:4]);
  assign offset      = Address[3:2];
  assign wr_data_out = MemWrite & hit & (offset == OFF_DATA_OUT);
  assign wr_status   = MemWrite & hit & (offset == OFF_STATUS);
  assign rd_data_in  = MemRead  & hit & (offset == OFF_DATA_IN);
  assign addr_unused = ^Address[1:0];

  // State
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        s3_q, s3_d;
  logic        ack_q, ack_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_full_q, rx_full_d;
  logic        rx_overrun_q, rx_overrun_d;
  tx_state_e   state_q, state_d;
  logic [31:0] port_out_q, port_out_d;
  logic        out_valid_q, out_valid_d;
  logic        tx_drop_q, tx_drop_d;
  logic        capture;

  // A rising edge of the synchronised strobe (s2 high, history s3 still low)
  // is one offer; s3 restarting at 0 after reset re-detects a held strobe.
  assign capture = s2_q & ~s3_q;

  // Next-state logic
  always_comb begin
    s1_d = PortInValid;
    s2_d = s1_q;
    s3_d = s2_q;
    ack_d = capture;

    rx_byte_d    = rx_byte_q;
    rx_full_d    = rx_full_q;
    rx_overrun_d = rx_overrun_q;

    // A same-edge pop frees the buffer, so the new byte loads without overrun.
    if (capture) begin
      rx_full_d = 1'b1;
      if (!rx_full_q || rd_data_in) begin
        rx_byte_d = PortIn;
      end
    end else if (rd_data_in) begin
      rx_full_d = 1'b0;
    end

    // Clear first, then set, so a same-cycle set event wins.
    if (wr_status && WriteData[2]) begin
      rx_overrun_d = 1'b0;
    end
    if (capture && rx_full_q && !rd_data_in) begin
      rx_overrun_d = 1'b1;
    end

    state_d    = state_q;
    port_out_d = port_out_q;
    tx_drop_d  = tx_drop_q;

    if (wr_status && WriteData[3]) begin
      tx_drop_d = 1'b0;
    end

    case (state_q)
      TX_IDLE: begin
        if (wr_data_out) begin
          port_out_d = WriteData;
          state_d    = TX_SEND;
        end
      end
      TX_SEND: begin
        // The word on PortOut is still owned by the device until this edge,
        // so a write here is lost even when it coincides with acceptance.
        if (wr_data_out) begin
          tx_drop_d = 1'b1;
        end
        if (PortOutReady) begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    out_valid_d = (state_d == TX_SEND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      ack_q        <= 1'b0;
      rx_byte_q    <= 8'h00;
      rx_full_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
      state_q      <= TX_IDLE;
      port_out_q   <= 32'h0;
      out_valid_q  <= 1'b0;
      tx_drop_q    <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      ack_q        <= ack_d;
      rx_byte_q    <= rx_byte_d;
      rx_full_q    <= rx_full_d;
      rx_overrun_q <= rx_overrun_d;
      state_q      <= state_d;
      port_out_q   <= port_out_d;
      out_valid_q  <= out_valid_d;
      tx_drop_q    <= tx_drop_d;
    end
  end

  // Load data
  always_comb begin
    ReadData = 32'h0;
    if (MemRead && hit) begin
      case (offset)
        OFF_DATA_OUT: ReadData = port_out_q;
        OFF_DATA_IN:  ReadData = {24'h0, rx_byte_q};
        OFF_STATUS:   ReadData = {28'h0, tx_drop_q, rx_overrun_q,
                                  (state_q == TX_SEND), rx_full_q};
        default:      ReadData = 32'h0;
      endcase
    end
  end

  assign PortInAck    = ack_q;
  assign PortOut      = port_out_q;
  assign PortOutValid = out_valid_q;

endmodule

// File: tb/tb_mmio_port_ctrl.sv
module tb_mmio_port_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = BASE;
  logic [31:0] WriteData = 32'h0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] ReadData;
  logic [7:0]  PortIn = 8'h00;
  logic        PortInValid = 1'b0;
  logic        PortInAck;
  logic [31:0] PortOut;
  logic        PortOutValid;
  logic        PortOutReady = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  mmio_port_ctrl #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
    .PortIn(PortIn), .PortInValid(PortInValid), .PortInAck(PortInAck),
    .PortOut(PortOut), .PortOutValid(PortOutValid), .PortOutReady(PortOutReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // Register-level view: a byte is taken on the third clock edge that sees the
  // strobe high after it was low (edge numbers kept in a queue).
  logic [31:0] m_out;
  logic [7:0]  m_byte;
  logic        m_busy, m_full, m_ovr, m_drop, m_ack, m_prev;
  int          m_edge;
  int          rise_q[$];
  logic        m_hit, m_cap, m_pop, m_wr0, set_ovr, set_drop;
  logic [1:0]  m_off;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_out = 0; m_byte = 0; m_busy = 0; m_full = 0; m_ovr = 0; m_drop = 0;
      m_ack = 0; m_prev = 0; m_edge = 0; rise_q.delete();
    end else begin
      m_edge++;
      m_hit = (Address[31:4] == BASE[31:4]);
      m_off = Address[3:2];
      m_cap = (rise_q.size() > 0) && (rise_q[0] + 2 == m_edge);
      if (m_cap) void'(rise_q.pop_front());
      if (PortInValid && !m_prev) rise_q.push_back(m_edge);
      m_prev = PortInValid;
      m_pop = MemRead && m_hit && (m_off == 2'd1);
      m_ack = m_cap;
      set_ovr = m_cap && m_full && !m_pop;
      if (m_cap) begin
        if (!set_ovr) m_byte = PortIn;
        m_full = 1;
      end else if (m_pop) m_full = 0;
      m_wr0 = MemWrite && m_hit && (m_off == 2'd0);
      set_drop = 0;
      if (!m_busy) begin
        if (m_wr0) begin m_out = WriteData; m_busy = 1; end
      end else begin
        if (m_wr0) set_drop = 1;
        if (PortOutReady) m_busy = 0;
      end
      if (MemWrite && m_hit && m_off == 2'd2) begin
        if (WriteData[2]) m_ovr = 0;
        if (WriteData[3]) m_drop = 0;
      end
      if (set_ovr) m_ovr = 1;
      if (set_drop) m_drop = 1;
    end
  end

  function automatic logic [31:0] exp_rd();
    logic [31:0] r;
    r = 0;
    if (MemRead && Address[31:4] == BASE[31:4]) begin
      case (Address[3:2])
        2'd0: r = m_out;
        2'd1: r = {24'h0, m_byte};
        2'd2: r = {28'h0, m_drop, m_ovr, m_busy, m_full};
        default: r = 0;
      endcase
    end
    return r;
  endfunction

  // Compare every cycle, mid-period, while inputs are stable.
  always @(negedge clk) begin
    check("PortOut", PortOut, m_out);
    check("PortOutValid", {31'h0, PortOutValid}, {31'h0, m_busy});
    check("PortInAck", {31'h0, PortInAck}, {31'h0, m_ack});
    check("ReadData", ReadData, exp_rd());
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk); #1;
  endtask

  task automatic read_chk(input logic [1:0] off, input logic [31:0] exp, input string name);
    Address = BASE + {28'h0, off, 2'b00};
    MemRead = 1;
    #1 check(name, ReadData, exp);
    cyc();
    MemRead = 0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] data);
    Address = BASE + {28'h0, off, 2'b00};
    WriteData = data;
    MemWrite = 1;
    cyc();
    MemWrite = 0;
  endtask

  task automatic capture(input logic [7:0] b);
    PortIn = b;
    PortInValid = 1;
    repeat (4) cyc();
    PortInValid = 0;
    repeat (2) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    // Reset state
    repeat (3) cyc();
    check("rst_PortOut", PortOut, 32'h0);
    check("rst_PortOutValid", {31'h0, PortOutValid}, 32'h0);
    check("rst_PortInAck", {31'h0, PortInAck}, 32'h0);
    reset = 1;
    cyc();
    read_chk(2'd2, 32'h0, "rst_status");

    // Receive: ack on the third edge sampling the strobe high
    PortIn = 8'hA5; PortInValid = 1;
    cyc(); cyc();
    check("rx_ack_edge2", {31'h0, PortInAck}, 32'h0);
    cyc();
    check("rx_ack_edge3", {31'h0, PortInAck}, 32'h1);
    cyc();
    check("rx_ack_edge4", {31'h0, PortInAck}, 32'h0);
    PortInValid = 0;
    cyc();
    read_chk(2'd2, 32'h1, "rx_status_full");
    read_chk(2'd1, 32'h0000_00A5, "rx_data");
    read_chk(2'd2, 32'h0, "rx_status_empty");

    // Overrun
    capture(8'h11);
    capture(8'h22);
    read_chk(2'd2, 32'h5, "ovr_status");
    read_chk(2'd1, 32'h11, "ovr_data_kept");
    wr(2'd2, 32'h4);
    read_chk(2'd2, 32'h0, "ovr_cleared");

    // Overrun set wins over a same-edge W1C clear
    capture(8'h44);
    PortIn = 8'h55; PortInValid = 1;
    cyc(); cyc();
    wr(2'd2, 32'h4);
    PortInValid = 0;
    cyc();
    read_chk(2'd2, 32'h5, "set_wins_status");
    read_chk(2'd1, 32'h44, "set_wins_data");
    wr(2'd2, 32'h4);
    read_chk(2'd2, 32'h0, "set_wins_cleared");

    // Simultaneous pop and capture
    capture(8'h33);
    PortIn = 8'h7E; PortInValid = 1;
    cyc(); cyc();
    read_chk(2'd1, 32'h33, "popcap_old");
    PortInValid = 0;
    read_chk(2'd2, 32'h1, "popcap_status");
    read_chk(2'd1, 32'h7E, "popcap_new");

    // Transmit: valid high for 5 cycles with 4 not-ready cycles
    PortOutReady = 0;
    wr(2'd0, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      check("tx_valid_wait", {31'h0, PortOutValid}, 32'h1);
      check("tx_port_out", PortOut, 32'hDEAD_BEEF);
      cyc();
    end
    PortOutReady = 1;
    check("tx_valid_last", {31'h0, PortOutValid}, 32'h1);
    cyc();
    PortOutReady = 0;
    check("tx_valid_done", {31'h0, PortOutValid}, 32'h0);
    check("tx_port_out_held", PortOut, 32'hDEAD_BEEF);
    read_chk(2'd2, 32'h0, "tx_status_idle");
    read_chk(2'd0, 32'hDEAD_BEEF, "tx_readback");

    // Drop while busy
    wr(2'd0, 32'h1);
    wr(2'd0, 32'h1234);
    check("drop_port_out", PortOut, 32'h1);
    read_chk(2'd2, 32'hA, "drop_status_busy");
    PortOutReady = 1; cyc(); PortOutReady = 0;
    read_chk(2'd2, 32'h8, "drop_status");
    wr(2'd2, 32'h8);
    read_chk(2'd2, 32'h0, "drop_cleared");

    // Drop on the acceptance cycle
    wr(2'd0, 32'h5);
    PortOutReady = 1;
    wr(2'd0, 32'h9);
    PortOutReady = 0;
    check("accdrop_port_out", PortOut, 32'h5);
    check("accdrop_valid", {31'h0, PortOutValid}, 32'h0);
    read_chk(2'd2, 32'h8, "accdrop_status");
    wr(2'd2, 32'hF);
    read_chk(2'd2, 32'h0, "accdrop_cleared");

    // Misses and writes to read-only/unmapped offsets have no effect
    Address = BASE + 32'h10; WriteData = 32'hFFFF_FFFF; MemWrite = 1;
    cyc(); MemWrite = 0;
    check("miss_valid", {31'h0, PortOutValid}, 32'h0);
    wr(2'd1, 32'hFF);
    wr(2'd3, 32'hFF);
    read_chk(2'd3, 32'h0, "unmapped_read");
    read_chk(2'd1, 32'h7E, "ro_data_in");
    Address = BASE + 32'h14; MemRead = 1;
    #1 check("miss_read", ReadData, 32'h0);
    cyc(); MemRead = 0;

    // Read and write together
    Address = BASE; WriteData = 32'h0BAD_F00D; MemWrite = 1; MemRead = 1;
    #1 check("rw_read_old", ReadData, 32'h5);
    cyc(); MemWrite = 0; MemRead = 0;
    check("rw_port_out", PortOut, 32'h0BAD_F00D);

    // Reset mid-transfer
    #2 reset = 0;
    #1 check("midrst_valid", {31'h0, PortOutValid}, 32'h0);
    check("midrst_port_out", PortOut, 32'h0);
    Address = BASE + 32'hC; MemRead = 1;
    #1 check("midrst_unmapped", ReadData, 32'h0);
    MemRead = 0;
    PortIn = 8'h3C; PortInValid = 1;
    cyc(); cyc();
    reset = 1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      acks += int'(PortInAck);
    end
    check("held_strobe_acks", acks, 1);
    check("held_strobe_valid", {31'h0, PortOutValid}, 32'h0);
    PortInValid = 0;
    cyc();
    read_chk(2'd1, 32'h3C, "held_strobe_data");

    cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
